// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - ID/EX hazard controller bus; HAZARD_PERF_EN adds perf counters
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2
);
  localparam int FSEL_W = $clog2(FWD_STAGES + 1);

  logic                  enable;
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  ex_branch_taken;
  logic                  stall_if_id;
  logic                  bubble_id_ex;
  logic                  flush_if_id;
  logic [FSEL_W-1:0]     fwd_sel_a;
  logic [FSEL_W-1:0]     fwd_sel_b;
`ifdef HAZARD_PERF_EN
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           perf_flush_cnt;
  logic [31:0]           perf_fwd_cnt;
`endif

  modport master (
`ifdef HAZARD_PERF_EN
    input  perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt,
`endif
    output enable, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output id_rd, id_reg_write, id_mem_read, ex_branch_taken,
    input  stall_if_id, bubble_id_ex, flush_if_id, fwd_sel_a, fwd_sel_b
  );

  modport slave (
`ifdef HAZARD_PERF_EN
    output perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt,
`endif
    input  enable, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  id_rd, id_reg_write, id_mem_read, ex_branch_taken,
    output stall_if_id, bubble_id_ex, flush_if_id, fwd_sel_a, fwd_sel_b
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - shadow-pipeline forwarding, load-use stall and branch squash
// Optional HAZARD_PERF_EN adds stall/flush/forward event counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  pipeline_hazard_ctrl_if.slave  bus
);
  localparam int FSEL_W = $clog2(FWD_STAGES + 1);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } entry_t;

  // stage_q[0] mirrors EX; stage_q[k] is the k-th producer stage after EX.
  entry_t stage_q [FWD_STAGES+1];
  entry_t id_entry;

  logic [FSEL_W-1:0] sel_a;
  logic [FSEL_W-1:0] sel_b;
  logic              load_use;
  logic              branch_flush;

  function automatic logic produces(input entry_t e, input logic [REG_ADDR_W-1:0] src);
    return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src);
  endfunction

  always_comb begin
    id_entry          = '0;
    id_entry.valid    = bus.id_valid;
    if (bus.id_valid) begin
      id_entry.rd        = bus.id_rd;
      id_entry.reg_write = bus.id_reg_write;
      id_entry.is_load   = bus.id_mem_read;
      id_entry.rs1       = bus.id_rs1;
      id_entry.rs2       = bus.id_rs2;
      id_entry.rs1_used  = bus.id_rs1_used;
      id_entry.rs2_used  = bus.id_rs2_used;
    end
  end

  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    load_use = 1'b0;
    // Walk oldest to youngest so the youngest producer overwrites older ones.
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (stage_q[0].valid && stage_q[0].rs1_used && produces(stage_q[k], stage_q[0].rs1))
        sel_a = FSEL_W'(k);
      if (stage_q[0].valid && stage_q[0].rs2_used && produces(stage_q[k], stage_q[0].rs2))
        sel_b = FSEL_W'(k);
    end
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (bus.id_valid && stage_q[j].is_load &&
          ((bus.id_rs1_used && produces(stage_q[j], bus.id_rs1)) ||
           (bus.id_rs2_used && produces(stage_q[j], bus.id_rs2))))
        load_use = 1'b1;
    end
  end

  assign branch_flush     = bus.ex_branch_taken & stage_q[0].valid;
  assign bus.flush_if_id  = branch_flush;
  assign bus.stall_if_id  = load_use & ~branch_flush;
  assign bus.bubble_id_ex = load_use | branch_flush;
  assign bus.fwd_sel_a    = sel_a;
  assign bus.fwd_sel_b    = sel_b;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int k = 0; k <= FWD_STAGES; k++) stage_q[k] <= '0;
    end else if (bus.enable) begin
      for (int k = FWD_STAGES; k >= 1; k--) stage_q[k] <= stage_q[k-1];
      stage_q[0] <= bus.bubble_id_ex ? '0 : id_entry;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      bus.perf_stall_cnt <= '0;
      bus.perf_flush_cnt <= '0;
      bus.perf_fwd_cnt   <= '0;
    end else if (bus.enable) begin
      if (bus.stall_if_id) bus.perf_stall_cnt <= bus.perf_stall_cnt + 32'd1;
      if (branch_flush)    bus.perf_flush_cnt <= bus.perf_flush_cnt + 32'd1;
      if ((sel_a != '0) || (sel_b != '0)) bus.perf_fwd_cnt <= bus.perf_fwd_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .FWD_STAGES(2)) bus ();

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .FWD_STAGES(2), .LOAD_LAT(1)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // {stall, bubble, flush, fwd_sel_a, fwd_sel_b}
  logic [6:0] obs;
  assign obs = {bus.stall_if_id, bus.bubble_id_ex, bus.flush_if_id, bus.fwd_sel_a, bus.fwd_sel_b};

  function automatic logic [6:0] ev(input logic s, input logic b, input logic f,
                                    input logic [1:0] a, input logic [1:0] bb);
    return {s, b, f, a, bb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs1_used  = u1;
    bus.id_rs2       = rs2;
    bus.id_rs2_used  = u2;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    bus.ex_branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    bus.enable = 1'b1;
    bus.ex_branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_id(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 1'($urandom));
      tick();
      @(negedge clk);
      checks++;
      if (obs !== 7'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %b want %b", i, obs, 7'd0);
      end
    end
    arst_n = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (obs !== 7'd0) begin
        errors++;
        $display("FAIL reset_idle[%0d] got %b want %b", i, obs, 7'd0);
      end
    end
  endtask

  task automatic test_alu_chain();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);   // sub x6,x5,x1
    @(negedge clk);
    checks++;
    if (obs !== 7'd0) begin
      errors++; $display("FAIL alu_first_in_ex got %b want %b", obs, 7'd0);
    end
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);   // or x7,x5,x3
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 0, 0, 2'd1, 2'd0)) begin
      errors++; $display("FAIL alu_fwd_stage1 got %b want %b", obs, ev(0, 0, 0, 2'd1, 2'd0));
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 0, 0, 2'd2, 2'd0)) begin
      errors++; $display("FAIL alu_fwd_stage2 got %b want %b", obs, ev(0, 0, 0, 2'd2, 2'd0));
    end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // lw x6,0(x2)
    tick();
    set_id(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);   // add x7,x6,x1
    @(negedge clk);
    checks++;
    if (obs !== ev(1, 1, 0, 2'd0, 2'd0)) begin
      errors++; $display("FAIL load_use_stall got %b want %b", obs, ev(1, 1, 0, 2'd0, 2'd0));
    end
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 7'd0) begin
      errors++; $display("FAIL load_use_release got %b want %b", obs, 7'd0);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 0, 0, 2'd2, 2'd0)) begin
      errors++; $display("FAIL load_use_fwd got %b want %b", obs, ev(0, 0, 0, 2'd2, 2'd0));
    end
    drain();
  endtask

  task automatic test_x0_and_priority();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);   // addi x0,x1,imm
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);   // add x8,x0,x0
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (obs !== 7'd0) begin
      errors++; $display("FAIL x0_no_forward got %b want %b", obs, 7'd0);
    end
    drain();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5,x1
    tick();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // addi x5,x2
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x5,x5
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 0, 0, 2'd1, 2'd1)) begin
      errors++; $display("FAIL youngest_wins got %b want %b", obs, ev(0, 0, 0, 2'd1, 2'd1));
    end
    drain();
  endtask

  task automatic test_branch_flush();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // lw x6
    tick();
    set_id(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);   // add x7,x6,x1
    bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 1, 1, 2'd0, 2'd0)) begin
      errors++; $display("FAIL branch_over_stall got %b want %b", obs, ev(0, 1, 1, 2'd0, 2'd0));
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (obs !== 7'd0) begin
      errors++; $display("FAIL branch_s0_invalid got %b want %b", obs, 7'd0);
    end
    drain();
  endtask

  task automatic test_enable_hold();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);   // add x5
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // lw x6,0(x5)
    tick();
    set_id(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0);   // add x7,x6,x5
    @(negedge clk);
    checks++;
    if (obs !== ev(1, 1, 0, 2'd1, 2'd0)) begin
      errors++; $display("FAIL hold_setup got %b want %b", obs, ev(1, 1, 0, 2'd1, 2'd0));
    end
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (obs !== ev(1, 1, 0, 2'd1, 2'd0)) begin
        errors++; $display("FAIL hold_frozen[%0d] got %b want %b", i, obs, ev(1, 1, 0, 2'd1, 2'd0));
      end
    end
    bus.enable = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 7'd0) begin
      errors++; $display("FAIL hold_resume_bubble got %b want %b", obs, 7'd0);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (obs !== ev(0, 0, 0, 2'd2, 2'd0)) begin
      errors++; $display("FAIL hold_resume_fwd got %b want %b", obs, ev(0, 0, 0, 2'd2, 2'd0));
    end
  endtask

  task automatic test_midstream_reset();
    set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // lw x6
    tick();
    set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);   // consumer of x6
    arst_n = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 7'd0) begin
      errors++; $display("FAIL midstream_reset got %b want %b", obs, 7'd0);
    end
    arst_n = 1'b1;
    drain();
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.ex_branch_taken = 1'b0;
    idle();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_x0_and_priority();
    test_branch_flush();
    test_enable_hold();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
